vend_change_sequencer: RTL and testbench

Controller for the vending machine's balance and change datapath. It accepts coin pulses, tracks the balance and the coin inventory, and issues a one-cycle vend. It then pays out change one coin at a time over a four-phase handshake with the coin hopper. It sits between the coin acceptor front end and the hopper/vend actuators.

---
 rtl/vend_change_sequencer_if.sv | 18 +
 rtl/vend_change_sequencer.sv | 153 +++++++++++++++
 tb/tb_vend_change_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_change_sequencer_if.sv
// rtl/vend_change_sequencer_if.sv - coin hopper request/acknowledge handshake
interface vend_change_sequencer_if;
  logic dispense_nickel;
  logic dispense_dime;
  logic hopper_ack;

  modport master (
    output dispense_nickel,
    output dispense_dime,
    input  hopper_ack
  );

  modport slave (
    input  dispense_nickel,
    input  dispense_dime,
    output hopper_ack
  );
endinterface

// File: rtl/vend_change_sequencer.sv
// rtl/vend_change_sequencer.sv - vending balance, coin inventory, vend and change payout controller
module vend_change_sequencer #(
  parameter int PRICE       = 30,
  parameter int N           = 6,
  parameter int MAX_BAL     = 60,
  parameter int INV_W       = 4,
  parameter int NICKEL_INIT = 8,
  parameter int DIME_INIT   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     nickel_in,
  input  logic                     dime_in,
  input  logic                     refund,
  output logic                     vend,
  output logic                     coin_reject,
  output logic                     change_short,
  output logic                     busy,
  output logic [N-1:0]             balance,
  output logic [INV_W-1:0]         nickel_cnt,
  output logic [INV_W-1:0]         dime_cnt,
  vend_change_sequencer_if.master  hopper
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VEND     = 3'd1,
    CHG_SEL  = 3'd2,
    DISP_REQ = 3'd3,
    DISP_REL = 3'd4
  } state_t;

  localparam logic [N-1:0]     PRICE_V    = N'(PRICE);
  localparam logic [N-1:0]     FIVE       = N'(5);
  localparam logic [N-1:0]     TEN        = N'(10);
  localparam logic [N:0]       MAX_V      = (N+1)'(MAX_BAL);
  localparam logic [INV_W-1:0] INV_FULL   = {INV_W{1'b1}};
  localparam logic [INV_W-1:0] INV_ONE    = INV_W'(1);
  localparam logic [INV_W-1:0] NICKEL_RST = INV_W'(NICKEL_INIT);
  localparam logic [INV_W-1:0] DIME_RST   = INV_W'(DIME_INIT);

  state_t state;
  state_t state_nxt;

  // sel_dime remembers which coin CHG_SEL picked for the current handshake
  logic         sel_dime;
  logic         coin_any;
  logic         coin_ok;
  logic         coin_full;
  logic [N-1:0] coin_val;
  logic [N:0]   coin_sum;
  logic         dime_avail;
  logic         nickel_avail;

  // coin acceptance and change availability, one bit wider so overflow is visible
  always_comb begin
    coin_any     = nickel_in | dime_in;
    coin_val     = dime_in ? TEN : FIVE;
    coin_sum     = {1'b0, balance} + {1'b0, coin_val};
    coin_full    = dime_in ? (dime_cnt == INV_FULL) : (nickel_cnt == INV_FULL);
    coin_ok      = coin_any && !(nickel_in && dime_in) && (state == IDLE) &&
                   (coin_sum <= MAX_V) && !coin_full;
    dime_avail   = (balance >= TEN) && (dime_cnt != '0);
    nickel_avail = (balance >= FIVE) && (nickel_cnt != '0);
  end

  // state register; reset aborts any open hopper transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state; IDLE decisions use the registered (pre-coin) balance
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (refund && (balance != '0)) begin
          state_nxt = CHG_SEL;
        end else if (balance >= PRICE_V) begin
          state_nxt = VEND;
        end
      end
      VEND:    state_nxt = CHG_SEL;
      CHG_SEL: begin
        if ((balance != '0) && (dime_avail || nickel_avail)) begin
          state_nxt = DISP_REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      DISP_REQ: if (hopper.hopper_ack) state_nxt = DISP_REL;
      DISP_REL: if (!hopper.hopper_ack) state_nxt = CHG_SEL;
      default:  state_nxt = IDLE;
    endcase
  end

  // decoded outputs; only one dispense line can be high since sel_dime picks one
  always_comb begin
    vend                   = (state == VEND);
    busy                   = (state != IDLE);
    change_short           = (state == CHG_SEL) && (balance != '0) && !dime_avail && !nickel_avail;
    hopper.dispense_dime   = (state == DISP_REQ) && sel_dime;
    hopper.dispense_nickel = (state == DISP_REQ) && !sel_dime;
  end

  // balance, inventory, coin selection and reject strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      balance     <= '0;
      nickel_cnt  <= NICKEL_RST;
      dime_cnt    <= DIME_RST;
      sel_dime    <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= coin_any && !coin_ok;
      case (state)
        IDLE: begin
          if (coin_ok) begin
            balance <= coin_sum[N-1:0];
            if (dime_in) begin
              dime_cnt <= dime_cnt + INV_ONE;
            end else begin
              nickel_cnt <= nickel_cnt + INV_ONE;
            end
          end
        end
        VEND:    balance <= balance - PRICE_V;
        CHG_SEL: sel_dime <= dime_avail;
        DISP_REQ: begin
          if (hopper.hopper_ack) begin
            if (sel_dime) begin
              if (dime_cnt != '0) begin
                balance  <= balance - TEN;
                dime_cnt <= dime_cnt - INV_ONE;
              end
            end else begin
              if (nickel_cnt != '0) begin
                balance    <= balance - FIVE;
                nickel_cnt <= nickel_cnt - INV_ONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_change_sequencer.sv
// tb/tb_vend_change_sequencer.sv - randomized bench with transaction-level vending model
module tb_vend_change_sequencer;

  localparam int PRICE = 30;
  localparam int MAX_BAL = 60;
  localparam int INV_MAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       nickel_in, dime_in, refund;
  logic       vend, coin_reject, change_short, busy;
  logic [5:0] balance;
  logic [3:0] nickel_cnt, dime_cnt;

  logic       n2_in, d2_in, r2_in;
  logic       vend2, reject2, short2, busy2;
  logic [5:0] balance2;
  logic [3:0] nickel2, dime2;

  vend_change_sequencer_if hop ();
  vend_change_sequencer_if hop2 ();

  vend_change_sequencer dut (
    .clk(clk), .reset(reset), .nickel_in(nickel_in), .dime_in(dime_in), .refund(refund),
    .vend(vend), .coin_reject(coin_reject), .change_short(change_short), .busy(busy),
    .balance(balance), .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt), .hopper(hop)
  );

  vend_change_sequencer #(.PRICE(25), .NICKEL_INIT(0), .DIME_INIT(0)) dut2 (
    .clk(clk), .reset(reset), .nickel_in(n2_in), .dime_in(d2_in), .refund(r2_in),
    .vend(vend2), .coin_reject(reject2), .change_short(short2), .busy(busy2),
    .balance(balance2), .nickel_cnt(nickel2), .dime_cnt(dime2), .hopper(hop2)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: balance/inventory in cents and coins, payouts as a coin list
  int m_bal, m_n, m_d;
  int e_vend, e_rej, e_short;
  int e_disp[$];

  function automatic void model_payout();
    while (m_bal > 0) begin
      if (m_bal >= 10 && m_d > 0) begin
        e_disp.push_back(10); m_bal -= 10; m_d--;
      end else if (m_bal >= 5 && m_n > 0) begin
        e_disp.push_back(5); m_bal -= 5; m_n--;
      end else begin
        e_short++;
        break;
      end
    end
  endfunction

  function automatic void model_settle();
    while (m_bal >= PRICE) begin
      e_vend++;
      m_bal -= PRICE;
      model_payout();
    end
  endfunction

  // observed events
  int o_vend = 0, o_rej = 0, o_short = 0, viol = 0;
  int o2_vend = 0, o2_short = 0;
  int o_disp[$];
  bit hold_ack = 1'b0;

  initial begin
    logic pn, pd;
    pn = 1'b0;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (vend) o_vend++;
        if (coin_reject) o_rej++;
        if (change_short) o_short++;
        if (vend2) o2_vend++;
        if (short2) o2_short++;
        if (hop.dispense_nickel && hop.dispense_dime) viol++;
        if (hop.dispense_nickel && !pn) o_disp.push_back(5);
        if (hop.dispense_dime && !pd) o_disp.push_back(10);
      end
      pn = hop.dispense_nickel;
      pd = hop.dispense_dime;
    end
  end

  // hopper responder with random ack assert/release latency
  initial begin
    hop.hopper_ack = 1'b0;
    forever begin
      tick();
      if (!hold_ack && (hop.dispense_nickel || hop.dispense_dime)) begin
        repeat ($urandom_range(1, 3)) tick();
        hop.hopper_ack = 1'b1;
        for (int i = 0; i < 50 && (hop.dispense_nickel || hop.dispense_dime); i++) tick();
        repeat ($urandom_range(0, 2)) tick();
        hop.hopper_ack = 1'b0;
      end
    end
  end

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int cyc = 0;
    while (quiet < 4 && cyc < 400) begin
      tick();
      cyc++;
      if (busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 4) check({tag, " idle_timeout"}, 0, 1);
  endtask

  task automatic compare_state(input string tag);
    check({tag, " balance"}, int'(balance), m_bal);
    check({tag, " nickel_cnt"}, int'(nickel_cnt), m_n);
    check({tag, " dime_cnt"}, int'(dime_cnt), m_d);
    check({tag, " vends"}, o_vend, e_vend);
    check({tag, " rejects"}, o_rej, e_rej);
    check({tag, " shorts"}, o_short, e_short);
    check({tag, " dispense_count"}, o_disp.size(), e_disp.size());
    for (int i = 0; i < e_disp.size() && i < o_disp.size(); i++)
      check({tag, " dispense_coin"}, o_disp[i], e_disp[i]);
    o_disp.delete();
    e_disp.delete();
  endtask

  // kind: 0 nickel, 1 dime, 2 both at once
  task automatic do_coin(input int kind);
    int v;
    bit acc;
    v = (kind == 1) ? 10 : 5;
    acc = (kind != 2) && (m_bal + v <= MAX_BAL) && (((kind == 1) ? m_d : m_n) < INV_MAX);
    nickel_in = (kind != 1);
    dime_in = (kind != 0);
    tick();
    nickel_in = 1'b0;
    dime_in = 1'b0;
    @(negedge clk);
    check("coin_reject_timing", int'(coin_reject), int'(!acc));
    if (acc && (m_bal + v >= PRICE)) begin
      check("vend_not_early", int'(vend), 0);
      @(negedge clk);
      check("vend_timing", int'(vend), 1);
    end
    if (acc) begin
      m_bal += v;
      if (kind == 1) m_d++;
      else m_n++;
      model_settle();
    end else begin
      e_rej++;
    end
    wait_idle("coin");
  endtask

  // refund pulse; optionally insert a coin while the hopper request is pending
  task automatic do_refund(input bit poke);
    int pre;
    int cyc;
    pre = e_disp.size();
    refund = 1'b1;
    tick();
    refund = 1'b0;
    if (m_bal > 0) begin
      model_payout();
      model_settle();
    end
    if (poke && e_disp.size() > pre) begin
      cyc = 0;
      while (!(hop.dispense_nickel || hop.dispense_dime) && cyc < 20) begin
        tick();
        cyc++;
      end
      if (cyc >= 20) check("poke dispense_timeout", 0, 1);
      dime_in = 1'b1;
      tick();
      dime_in = 1'b0;
      e_rej++;
    end
    wait_idle("refund");
  endtask

  task automatic clear_books();
    m_bal = 0; m_n = 8; m_d = 8;
    e_vend = 0; e_rej = 0; e_short = 0;
    o_vend = 0; o_rej = 0; o_short = 0;
    o2_vend = 0; o2_short = 0;
    e_disp.delete();
    o_disp.delete();
  endtask

  initial begin
    int r;
    int cyc;
    reset = 1'b1;
    nickel_in = 1'b0; dime_in = 1'b0; refund = 1'b0;
    n2_in = 1'b0; d2_in = 1'b0; r2_in = 1'b0;
    hop2.hopper_ack = 1'b0;
    clear_books();
    repeat (3) tick();
    check("reset balance", int'(balance), 0);
    check("reset nickel_cnt", int'(nickel_cnt), 8);
    check("reset dime_cnt", int'(dime_cnt), 8);
    check("reset busy", int'(busy), 0);
    check("reset dispense", int'(hop.dispense_nickel | hop.dispense_dime), 0);
    reset = 1'b0;
    tick();

    repeat (3) do_coin(1);
    compare_state("three_dimes");

    do_coin(1); do_coin(1); do_coin(0); do_coin(1);
    compare_state("thirty_five");

    do_coin(1); do_coin(1); do_coin(0);
    do_refund(1'b1);
    compare_state("refund_25");

    do_coin(2);
    compare_state("both_coins");

    // reset while a dime request waits for an ack that never comes
    do_coin(1);
    compare_state("pre_reset");
    hold_ack = 1'b1;
    refund = 1'b1;
    tick();
    refund = 1'b0;
    cyc = 0;
    while (!hop.dispense_dime && cyc < 20) begin
      tick();
      cyc++;
    end
    check("abort dispense_dime_seen", int'(hop.dispense_dime), 1);
    reset = 1'b1;
    #1;
    check("abort dispense_dime", int'(hop.dispense_dime), 0);
    check("abort busy", int'(busy), 0);
    check("abort balance", int'(balance), 0);
    check("abort nickel_cnt", int'(nickel_cnt), 8);
    check("abort dime_cnt", int'(dime_cnt), 8);
    tick();
    tick();
    clear_books();
    reset = 1'b0;
    hold_ack = 1'b0;
    tick();
    check("after_abort busy", int'(busy), 0);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 99);
      if (r < 40) do_coin(0);
      else if (r < 75) do_coin(1);
      else if (r < 82) do_coin(2);
      else do_refund(1'($urandom_range(0, 1)));
      compare_state("random");
    end

    // second controller: 25c price, empty inventory, 5c change cannot be paid
    for (int k = 0; k < 3; k++) begin
      d2_in = 1'b1;
      tick();
      d2_in = 1'b0;
      tick();
    end
    repeat (10) tick();
    check("short vends", o2_vend, 1);
    check("short pulses", o2_short, 1);
    check("short balance", int'(balance2), 5);
    check("short busy", int'(busy2), 0);
    check("short dime_cnt", int'(dime2), 3);
    check("short nickel_cnt", int'(nickel2), 0);

    check("one_dispense_at_a_time", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
